// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
//
// Load/store initiator between the execute stage and a word-addressed data
// memory that only performs full 32-bit writes. Byte-addressed RV32 loads and
// stores (LB/LH/LW/LBU/LHU/SB/SH/SW) are turned into word accesses:
//   - loads read one word and sign/zero-extend the selected byte or half,
//   - SW writes the word directly,
//   - SB/SH read the old word, merge the new lane and write the whole word.
// Misaligned, out-of-range and illegal-funct3 requests are answered with an
// error response and never touch memory.
//
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_req_*          request handshake: valid/ready, we, funct3, byte address,
//                    right-aligned store data
//   o_rsp_*          single-cycle response pulse with extended load data and
//                    error flag (no backpressure)
//   o_mem_*          word-addressed memory port: write enable, word address,
//                    write data
//   i_mem_rdata      memory read data for o_mem_addr
//
// All outputs come straight from flops; the next-state process computes the
// values they will hold in the following state.
// -----------------------------------------------------------------------------
module lsu_mem_port #(
  parameter  int MEM_SIZE = 1024,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Legal funct3 for the direction, natural alignment, and word index in range.
  function automatic logic req_ok(input logic        we,
                                  input logic [2:0]  f3,
                                  input logic [31:0] addr);
    logic f3_ok;
    logic align_ok;
    logic range_ok;
    case (f3)
      3'b000: begin
        f3_ok    = 1'b1;
        align_ok = 1'b1;
      end
      3'b001: begin
        f3_ok    = 1'b1;
        align_ok = ~addr[0];
      end
      3'b010: begin
        f3_ok    = 1'b1;
        align_ok = (addr[1:0] == 2'b00);
      end
      3'b100: begin
        f3_ok    = ~we;
        align_ok = 1'b1;
      end
      3'b101: begin
        f3_ok    = ~we;
        align_ok = ~addr[0];
      end
      default: begin
        f3_ok    = 1'b0;
        align_ok = 1'b0;
      end
    endcase
    range_ok = ({2'b00, addr[31:2]} < 32'(MEM_SIZE));
    return f3_ok & align_ok & range_ok;
  endfunction

  // Select the addressed byte/half of a read word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Replace one byte or half lane of the old word; other lanes pass through.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [15:0] wd,
                                              input logic        is_half,
                                              input logic [1:0]  off);
    logic [31:0] w;
    w = old_word;
    if (is_half) begin
      if (off[1]) begin
        w[31:16] = wd;
      end else begin
        w[15:0] = wd;
      end
    end else begin
      case (off)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        2'd3:    w[31:24] = wd[7:0];
        default: w        = old_word;
      endcase
    end
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic                we_q,        we_d;
  logic [2:0]          funct3_q,    funct3_d;
  logic [1:0]          off_q,       off_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  // Only the low half is ever needed: SW is issued straight from the request.
  logic [15:0]         wdata_q,     wdata_d;

  logic                ready_q,     ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  // Next-state and next-output logic; outputs default to their idle value.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    rsp_err_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {ADDR_W{1'b0}};
    mem_wdata_d = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          we_d     = i_req_we;
          funct3_d = i_req_funct3;
          off_d    = i_req_addr[1:0];
          idx_d    = i_req_addr[ADDR_W+1:2];
          wdata_d  = i_req_wdata[15:0];
          if (!req_ok(i_req_we, i_req_funct3, i_req_addr)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (i_req_we && (i_req_funct3 == 3'b010)) begin
            // Full-word store needs no read of the old contents.
            state_d     = ST_WR;
            mem_we_d    = 1'b1;
            mem_addr_d  = i_req_addr[ADDR_W+1:2];
            mem_wdata_d = i_req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_d    = ST_RD;
            mem_addr_d = i_req_addr[ADDR_W+1:2];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD: begin
        // i_mem_rdata has been stable against idx_q for the whole RD cycle.
        if (we_q) begin
          state_d     = ST_WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = store_merge(i_mem_rdata, wdata_q, funct3_q[0], off_q);
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extend(i_mem_rdata, funct3_q, off_q);
        end
      end

      ST_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      idx_q       <= {ADDR_W{1'b0}};
      wdata_q     <= 16'h0000;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
`timescale 1ns/1ps
module tb_lsu_mem_port;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_f3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int errors = 0;
  int checks = 0;

  // Word memory seen by the DUT and byte-level reference image.
  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [7:0]  ref_mem [0:4*MEM_WORDS-1];

  // Bus monitor state.
  int            we_cnt = 0;
  int            rsp_cnt = 0;
  int            rsp_long = 0;
  int            we_long = 0;
  int            idle_leak = 0;
  int            wdata_leak = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [31:0]   last_we_data = 32'h0;
  logic          prev_rsp = 1'b0;
  logic          prev_we = 1'b0;

  always #5 clk = ~clk;

  lsu_mem_port #(.MEM_SIZE(MEM_WORDS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_funct3 (req_f3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  // Memory: word w starts out holding the value w.
  initial begin
    for (int w = 0; w < MEM_WORDS; w++) mem[w] = 32'(w);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  // Protocol monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        we_cnt       <= we_cnt + 1;
        last_we_addr <= mem_addr;
        last_we_data <= mem_wdata;
        if (prev_we) we_long <= we_long + 1;
      end else if (mem_wdata !== 32'h0) begin
        wdata_leak <= wdata_leak + 1;
      end
      if (rsp_valid) begin
        rsp_cnt <= rsp_cnt + 1;
        if (prev_rsp) rsp_long <= rsp_long + 1;
      end else if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        idle_leak <= idle_leak + 1;
      end
    end
    prev_we  <= mem_we;
    prev_rsp <= rsp_valid;
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int ref_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_is_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(f3);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    if ((a % sz) != 0) return 1'b1;
    if ((a >> 2) >= MEM_WORDS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(f3);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    // Signed sub-word: subtract 2^(8*sz) when the top bit is set.
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz = ref_size(f3);
    for (int i = 0; i < sz; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
  endtask

  // One request: returns response data, error, latency (-1 on timeout), writes seen.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nwr);
    int w0;
    int waitc;
    rd  = 32'hDEAD_BEEF;
    er  = 1'bx;
    lat = -1;
    @(negedge clk);
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_f3    = f3;
    req_addr  = addr;
    req_wdata = wd;
    w0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_f3    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    for (int c = 1; c <= 8; c++) begin
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
      @(negedge clk);
    end
    nwr = we_cnt - w0;
    if (we && !ref_is_err(we, f3, addr)) ref_store(f3, addr, wd);
  endtask

  // ------------------------------- tests -----------------------------------
  task automatic test_reset();
    logic [3+64+AW-1:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b rsp_valid=%b expected 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_sw();
    logic [31:0] rd;
    logic er;
    int lat, nwr;
    do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, rd, er, lat, nwr);
    checks++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp: lat=%0d err=%b rdata=%h expected 2/0/0", lat, er, rd);
    end
    checks++;
    if (nwr !== 1 || last_we_addr !== 10'd4 || last_we_data !== 32'h80FF7F01) begin
      errors++;
      $display("FAIL sw_write: n=%0d addr=%0d data=%h expected 1/4/80ff7f01", nwr, last_we_addr, last_we_data);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ads [6] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp [6] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                             32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
    logic [31:0] rd;
    logic er;
    int lat, nwr;
    for (int k = 0; k < 6; k++) begin
      do_req(1'b0, f3s[k], ads[k], 32'h0, rd, er, lat, nwr);
      checks++;
      if (rd !== exp[k] || er !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: rdata=%h err=%b expected %h/0", k, rd, er, exp[k]);
      end
      checks++;
      if (lat !== 2 || nwr !== 0) begin
        errors++;
        $display("FAIL load_%0d_timing: lat=%0d writes=%0d expected 2/0", k, lat, nwr);
      end
    end
  endtask

  task automatic test_sb();
    logic [31:0] rd;
    logic er;
    int lat, nwr;
    do_req(1'b1, 3'b000, 32'h0D, 32'h123456AA, rd, er, lat, nwr);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL sb_rsp: lat=%0d err=%b rdata=%h expected 3/0/0", lat, er, rd);
    end
    checks++;
    if (nwr !== 1 || last_we_addr !== 10'd3 || last_we_data !== 32'h0000AA03) begin
      errors++;
      $display("FAIL sb_write: n=%0d addr=%0d data=%h expected 1/3/0000aa03", nwr, last_we_addr, last_we_data);
    end
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, rd, er, lat, nwr);
    checks++;
    if (rd !== 32'h0000AA03) begin
      errors++;
      $display("FAIL sb_readback: got %h expected 0000aa03", rd);
    end
  endtask

  task automatic test_errors();
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b011, 3'b010};
    logic [31:0] ads [4] = '{32'h11, 32'h12, 32'h00, 32'h1000};
    logic [31:0] rd;
    logic er;
    int lat, nwr;
    for (int k = 0; k < 4; k++) begin
      do_req(wes[k], f3s[k], ads[k], 32'hFFFF_FFFF, rd, er, lat, nwr);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nwr !== 0) begin
        errors++;
        $display("FAIL err_%0d: err=%b rdata=%h lat=%0d writes=%0d expected 1/0/1/0", k, er, rd, lat, nwr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3+64+AW-1:0] outs;
    logic [31:0] rd;
    logic er;
    int lat, nwr, r0, w0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_f3    = 3'b001;
    req_addr  = 32'h08;
    req_wdata = 32'h0000BEEF;
    r0 = rsp_cnt;
    w0 = we_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    outs = {rsp_valid, rsp_err, mem_we, rsp_rdata, mem_addr, mem_wdata};
    checks++;
    if (outs !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: outs=%h ready=%b expected 0/1", outs, req_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_cnt !== r0 || we_cnt !== w0) begin
      errors++;
      $display("FAIL midreset_quiet: rsp=%0d writes=%0d expected 0/0", rsp_cnt - r0, we_cnt - w0);
    end
    do_req(1'b0, 3'b010, 32'h08, 32'h0, rd, er, lat, nwr);
    checks++;
    if (rd !== 32'h00000002 || er !== 1'b0) begin
      errors++;
      $display("FAIL midreset_word2: got %h err=%b expected 00000002/0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ads [3] = '{32'h10, 32'h0C, 32'h04};
    logic [31:0] exp [3];
    logic [31:0] rdv [3];
    int acc [3];
    int rc  [3];
    int na = 0;
    int nr = 0;
    for (int k = 0; k < 3; k++) begin
      exp[k] = ref_load(3'b010, ads[k]);
      acc[k] = -100;
      rc[k]  = -100;
      rdv[k] = 32'hDEAD_BEEF;
    end
    @(negedge clk);
    for (int cyc = 0; cyc < 30 && nr < 3; cyc++) begin
      if (rsp_valid && nr < 3) begin
        rc[nr]  = cyc;
        rdv[nr] = rsp_rdata;
        nr++;
      end
      if (req_ready) begin
        if (na < 3) begin
          req_valid = 1'b1;
          req_we    = 1'b0;
          req_f3    = 3'b010;
          req_addr  = ads[na];
          acc[na]   = cyc;
          na++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (na !== 3 || acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
      errors++;
      $display("FAIL b2b_accepts: n=%0d gaps=%0d,%0d expected 3/3,3", na, acc[1] - acc[0], acc[2] - acc[1]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdv[k] !== exp[k] || rc[k] - acc[k] !== 2) begin
        errors++;
        $display("FAIL b2b_rsp_%0d: rdata=%h lat=%0d expected %h/2", k, rdv[k], rc[k] - acc[k], exp[k]);
      end
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd, exp_rd;
    logic        er, exp_er;
    int lat, nwr, exp_lat, exp_nwr;
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      exp_er  = ref_is_err(we, f3, a);
      exp_rd  = (exp_er || we) ? 32'h0 : ref_load(f3, a);
      exp_lat = exp_er ? 1 : ((we && f3 != 3'b010) ? 3 : 2);
      exp_nwr = (!exp_er && we) ? 1 : 0;
      do_req(we, f3, a, wd, rd, er, lat, nwr);
      checks++;
      if (er !== exp_er || rd !== exp_rd || lat !== exp_lat || nwr !== exp_nwr ||
          (exp_nwr == 1 && last_we_addr !== a[AW+1:2])) begin
        errors++;
        $display("FAIL rand_%0d we=%b f3=%0d addr=%h: err=%b rd=%h lat=%0d wr=%0d expected %b/%h/%0d/%0d",
                 n, we, f3, a, er, rd, lat, nwr, exp_er, exp_rd, exp_lat, exp_nwr);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (rsp_long !== 0 || we_long !== 0) begin
      errors++;
      $display("FAIL pulse_width: long_rsp=%0d long_we=%0d expected 0/0", rsp_long, we_long);
    end
    checks++;
    if (idle_leak !== 0 || wdata_leak !== 0) begin
      errors++;
      $display("FAIL idle_outputs: rsp_leak=%0d wdata_leak=%0d expected 0/0", idle_leak, wdata_leak);
    end
  endtask

  task automatic test_final_mem();
    int bad = 0;
    logic [31:0] w;
    for (int i = 0; i < MEM_WORDS; i++) begin
      w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      if (mem[i] !== w) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL final_memory: %0d words differ, expected 0", bad);
    end
  endtask

  initial begin
    for (int w = 0; w < MEM_WORDS; w++) begin
      for (int i = 0; i < 4; i++) ref_mem[4*w+i] = 8'(w >> (8 * i));
    end
    test_reset();
    test_sw();
    test_loads();
    test_sb();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    test_protocol();
    test_final_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
